// File: rtl/mem_arbiter_if.sv
// Request/response bundle for one requester port of mem_arbiter.
// The requester (master) drives the request fields and holds them stable
// until it sees gnt; the arbiter (slave) returns gnt, rvalid and rdata.
interface mem_arbiter_if;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [15:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a 256x16 RAM with separate read and write
// ports and a 1-cycle registered read. Port A (load/store) has priority;
// port B (instruction fetch) wins a conflict once it has been blocked for
// STARVE_LIMIT consecutive cycles. Read responses are steered back to the
// port that issued the read using a one-entry owner tag.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  a_if,
    mem_arbiter_if.slave  b_if,
    output logic          mem_rd_en_o,
    output logic [7:0]    mem_rd_addr_o,
    output logic          mem_wr_en_o,
    output logic [7:0]    mem_wr_addr_o,
    output logic [15:0]   mem_wdata_o,
    input  logic [15:0]   mem_rdata_i,
    input  logic          mem_rvalid_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rd_owner_q, rd_owner_d;   // 0 = A, 1 = B
    logic       rd_pend_q, rd_pend_d;

    logic starve_flag;
    logic same_type;
    logic addr_eq;
    logic conflict;
    logic b_wins;
    logic a_gnt, b_gnt;
    logic a_rd_go, b_rd_go, a_wr_go, b_wr_go;

    // Grant resolution: at most one read and one write per cycle.
    always_comb begin
        starve_flag = (starve_cnt_q == LIMIT);
        same_type   = (a_if.we == b_if.we);
        addr_eq     = (a_if.addr == b_if.addr);
        // Two reads or two writes always collide; a read and a write only
        // collide on the same address (read-after-write ordering).
        conflict    = a_if.req & b_if.req & (same_type | addr_eq);
        // Starved B wins any conflict; otherwise on a same-address
        // read/write pair the writer wins, and A wins same-type conflicts.
        b_wins      = starve_flag | (!same_type & b_if.we);
        a_gnt       = !rst & a_if.req & !(conflict & b_wins);
        b_gnt       = !rst & b_if.req & !(conflict & !b_wins);
        a_rd_go     = a_gnt & !a_if.we;
        b_rd_go     = b_gnt & !b_if.we;
        a_wr_go     = a_gnt & a_if.we;
        b_wr_go     = b_gnt & b_if.we;
    end

    // RAM port drive: address/data muxed from the granted reader/writer.
    always_comb begin
        mem_rd_en_o   = a_rd_go | b_rd_go;
        mem_rd_addr_o = b_rd_go ? b_if.addr : a_if.addr;
        mem_wr_en_o   = a_wr_go | b_wr_go;
        mem_wr_addr_o = b_wr_go ? b_if.addr : a_if.addr;
        mem_wdata_o   = b_wr_go ? b_if.wdata : a_if.wdata;
    end

    // Next-state for the read tag and the starvation counter.
    always_comb begin
        // NOTE: every combinational output gets a value on every path
        // (defaults first), otherwise synthesis infers a latch.
        starve_cnt_d = '0;
        rd_pend_d    = mem_rd_en_o;
        rd_owner_d   = mem_rd_en_o ? b_rd_go : rd_owner_q;
        if (b_if.req && !b_gnt) begin
            starve_cnt_d = starve_flag ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            starve_cnt_q <= '0;
            rd_owner_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

    // Port responses: grants are combinational, read data is steered by
    // the owner tag; a response arriving while rst is high is dropped.
    always_comb begin
        a_if.gnt    = a_gnt;
        b_if.gnt    = b_gnt;
        a_if.rvalid = !rst & rd_pend_q & mem_rvalid_i & !rd_owner_q;
        b_if.rvalid = !rst & rd_pend_q & mem_rvalid_i & rd_owner_q;
        a_if.rdata  = mem_rdata_i;
        b_if.rdata  = mem_rdata_i;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port request arbiter placed directly upstream of the 256x16 block RAM (separate read/write ports, 1-cycle registered read with `valid_out`). Port A serves load/store traffic and has priority. Port B serves instruction fetch and has starvation protection. The block issues at most one read and one write to the RAM per cycle and routes each read response back to the port that issued it.

## Interface
- `STARVE_LIMIT`, 4: consecutive blocked cycles of port B after which B wins the next conflict; range 1–15.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_req` / `b_req` in 1: request valid; held with fields stable until granted.
- `a_we` / `b_we` in 1: 1 = write, 0 = read.
- `a_addr` / `b_addr` in 8: word address.
- `a_wdata` / `b_wdata` in 16: write data.
- `a_gnt` / `b_gnt` out 1: combinational; request is accepted in a cycle where `req & gnt` is true.
- `a_rvalid` / `b_rvalid` out 1: read data valid for that port, one pulse per granted read.
- `rdata` out 16: read data, shared by both ports; qualified by the `*_rvalid` outputs.
- `mem_rd_en` out 1, `mem_rd_addr` out 8: drive the RAM read port.
- `mem_wr_en` out 1, `mem_wr_addr` out 8, `mem_wdata` out 16: drive the RAM write port.
- `mem_rdata` in 16, `mem_rvalid` in 1: RAM `data_out` / `valid_out`.

## Operation
- **Grant resolution.** Each cycle the arbiter resolves at most one read and one write.
- **One port requesting.** That port is granted.
- **Both read, or both write (same-type conflict).** One port is granted. Normally A wins. B wins instead when `starve_flag` is set.
- **One read and one write, different addresses.** Both ports are granted in the same cycle. Write and read go to the RAM concurrently.
- **One read and one write, same address.** Only one port is granted. Normally the writer wins, so the read retries next cycle and returns the new data. If `starve_flag` is set and B is requesting, B wins; when B is the reader, it receives the pre-write value.
- **Starvation counter.** 4-bit `starve_cnt`, reset value 0.
  - Increments in each cycle where `b_req & !b_gnt`, saturating at `STARVE_LIMIT`.
  - Clears in any cycle where `b_req & b_gnt`, or where `!b_req`.
  - `starve_flag = (starve_cnt == STARVE_LIMIT)`.
- **RAM drive.** `mem_rd_en` = a granted read; address muxed from the winning reader. `mem_wr_en` = a granted write; address and data muxed from the winning writer.
- **Read tag.** Register `rd_owner`: 0 = A, 1 = B, loaded on each granted read. Register `rd_pend`, reset value 0, set to `mem_rd_en`.
- **Read return.**
  - `a_rvalid = rd_pend & mem_rvalid & !rd_owner`.
  - `b_rvalid = rd_pend & mem_rvalid & rd_owner`.
  - `rdata = mem_rdata`.
- **Write completion.** Writes complete at grant. There is no write response.

## Timing
- **Reset values.** `rd_pend` = 0, `rd_owner` = 0, `starve_cnt` = 0.
  - `a_rvalid` and `b_rvalid` are 0 in the first cycle after reset, irrespective of `mem_rvalid`.
  - `*_gnt` and `mem_*_en` are combinational from the requests; they are forced to 0 while `rst` is high.
- **Read latency.** Grant in cycle N gives `*_rvalid` high in cycle N+1, with `rdata` valid in that same cycle.
- **Throughput.** One read per cycle, back to back, with no bubble. One read plus one write per cycle when addresses differ.
- **Reset mid-read.** If `rst` is high in cycle N+1 of an outstanding read, the response is dropped and no `*_rvalid` is asserted.
- **Request stability.** A port deasserting `req` before grant is legal; nothing is issued for it.
- **Starvation bound.** Port B is granted within `STARVE_LIMIT`+1 cycles of asserting `req`.

## Test plan
- **Single-port write then read.** A writes 0xBEEF to address 0x10, then reads 0x10. Required: `a_gnt` high both cycles; `a_rvalid` high one cycle after the read grant with `rdata` = 0xBEEF; `b_rvalid` stays 0.
- **Concurrent read/write, different addresses.** A writes 0x1234 to 0x20 while B reads 0x21 (preloaded 0x5555), same cycle. Required: both granted; next cycle `b_rvalid` = 1 with `rdata` = 0x5555.
- **Same-address hazard.** A writes 0xAAAA to 0x30 while B reads 0x30 (old value 0x0001). Required: only `a_gnt` in cycle N; `b_gnt` in N+1; `b_rvalid` in N+2 with `rdata` = 0xAAAA.
- **Starvation.** A and B issue continuous reads, `STARVE_LIMIT` = 4. Required: `b_gnt` high on the 5th cycle of B requesting, then `starve_cnt` returns to 0; A regains priority afterwards.
- **Reset mid-read.** A read is granted in cycle N and `rst` is asserted in cycle N+1. Required: `a_rvalid` = 0 in N+1 and N+2. After release, a new read of a known address returns correct data.
- **Back-to-back reads.** A reads 0x00..0x07 on consecutive cycles. Required: 8 consecutive `a_rvalid` pulses, in order, with matching data.
